// File: rtl/uart_rx_keymatch.sv
// Oversampling UART receiver with a configurable frame format and a synchronised RxD input.
// It also drives a retriggerable level that is held high after a received word equals MATCH_KEY.
module uart_rx_keymatch #(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter int         BAUD_RATE   = 9_600,
    parameter int         OVERSAMPLE  = 16,
    parameter int         DATA_BITS   = 8,
    parameter int         PARITY      = 0,
    parameter logic [8:0] MATCH_KEY   = 9'h078,
    parameter int         HOLD_CYCLES = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 match_level
);

    localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0]     SMP_HALF   = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0]     SMP_LAST   = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DATA_BITS-1:0] KEY        = MATCH_KEY[DATA_BITS-1:0];
    localparam logic                 HAS_PARITY = (PARITY != 0);
    localparam logic                 ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_e;

    state_e               state_q;
    logic                 rxMeta_q;
    logic                 rxs_q;
    logic [DIV_W-1:0]     divCnt_q;
    logic                 tick;
    logic [SMP_W-1:0]     sampleCnt_q;
    logic [BIT_W-1:0]     bitCnt_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 parMismatch_q;
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q;
    logic                 parityErr_q;
    logic                 frameErr_q;
    logic                 matchLevel_q;
    logic [HOLD_W-1:0]    holdCnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxs_q    <= 1'b1;
        end else begin
            rxMeta_q <= rxd;
            rxs_q    <= rxMeta_q;
        end
    end

    assign tick = (divCnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
        end
    end

    // Pulses default low every clk; they are set only by the tick that decides the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sampleCnt_q   <= '0;
            bitCnt_q      <= '0;
            word_q        <= '0;
            parMismatch_q <= 1'b0;
            rxData_q      <= '0;
            rxValid_q     <= 1'b0;
            parityErr_q   <= 1'b0;
            frameErr_q    <= 1'b0;
        end else begin
            rxValid_q   <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rxs_q) begin
                            sampleCnt_q   <= '0;
                            parMismatch_q <= 1'b0;
                            state_q       <= START;
                        end
                    end
                    START: begin
                        if (sampleCnt_q == SMP_HALF) begin
                            if (rxs_q) begin
                                state_q <= IDLE;
                            end else begin
                                sampleCnt_q <= '0;
                                bitCnt_q    <= '0;
                                state_q     <= DATA;
                            end
                        end else begin
                            sampleCnt_q <= sampleCnt_q + SMP_W'(1);
                        end
                    end
                    DATA: begin
                        if (sampleCnt_q == SMP_LAST) begin
                            word_q      <= {rxs_q, word_q[DATA_BITS-1:1]};
                            sampleCnt_q <= '0;
                            if (bitCnt_q == BIT_LAST) begin
                                bitCnt_q <= '0;
                                state_q  <= HAS_PARITY ? PAR : STOP;
                            end else begin
                                bitCnt_q <= bitCnt_q + BIT_W'(1);
                            end
                        end else begin
                            sampleCnt_q <= sampleCnt_q + SMP_W'(1);
                        end
                    end
                    PAR: begin
                        if (sampleCnt_q == SMP_LAST) begin
                            parMismatch_q <= ((^word_q) ^ rxs_q) != ODD_PARITY;
                            sampleCnt_q   <= '0;
                            state_q       <= STOP;
                        end else begin
                            sampleCnt_q <= sampleCnt_q + SMP_W'(1);
                        end
                    end
                    STOP: begin
                        if (sampleCnt_q == SMP_LAST) begin
                            sampleCnt_q <= '0;
                            if (!rxs_q) begin
                                frameErr_q <= 1'b1;
                                state_q    <= BREAK;
                            end else if (parMismatch_q) begin
                                parityErr_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                rxData_q  <= word_q;
                                rxValid_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end else begin
                            sampleCnt_q <= sampleCnt_q + SMP_W'(1);
                        end
                    end
                    BREAK: begin
                        if (rxs_q) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // A matching good word (re)starts the hold window; anything else only lets it run down.
    always_ff @(posedge clk) begin
        if (reset) begin
            matchLevel_q <= 1'b0;
            holdCnt_q    <= '0;
        end else if (rxValid_q && (rxData_q == KEY)) begin
            matchLevel_q <= 1'b1;
            holdCnt_q    <= '0;
        end else if (matchLevel_q) begin
            if (holdCnt_q == HOLD_LAST) begin
                matchLevel_q <= 1'b0;
            end else begin
                holdCnt_q <= holdCnt_q + HOLD_W'(1);
            end
        end
    end

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign parity_err  = parityErr_q;
    assign frame_err   = frameErr_q;
    assign match_level = matchLevel_q;

endmodule

// File: tb/tb_uart_rx_keymatch.sv
// Directed bench for uart_rx_keymatch: instance 0 (no parity, 1000-clk hold), instance 1 (even parity)
// and instance 2 (no parity, 3000-clk hold, sharing instance 0's line so a retrigger fits between frames).
module tb_uart_rx_keymatch;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxdA;
    logic       rxdB;
    logic [7:0] rxData     [3];
    logic       rxValid    [3];
    logic       parityErr  [3];
    logic       frameErr   [3];
    logic       matchLevel [3];

    int    testsRun  = 0;
    int    failCount = 0;
    longint cyc      = 0;
    int    validCnt [3] = '{0, 0, 0};
    int    parCnt   [3] = '{0, 0, 0};
    int    frameCnt [3] = '{0, 0, 0};
    int    rises    [3] = '{0, 0, 0};
    int    runCur   [3] = '{0, 0, 0};
    int    lastRun  [3] = '{0, 0, 0};
    longint lastValidCyc [3] = '{0, 0, 0};
    int    multiPulse = 0;
    int    baseValid [3];
    int    basePar   [3];
    int    baseFrame [3];
    int    baseRises [3];

    always #5 clk = ~clk;

    uart_rx_keymatch #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .MATCH_KEY(9'h078), .HOLD_CYCLES(1000)
    ) dutA (
        .clk(clk), .reset(reset), .rxd(rxdA), .rx_data(rxData[0]), .rx_valid(rxValid[0]),
        .parity_err(parityErr[0]), .frame_err(frameErr[0]), .match_level(matchLevel[0])
    );

    uart_rx_keymatch #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .MATCH_KEY(9'h078), .HOLD_CYCLES(1000)
    ) dutB (
        .clk(clk), .reset(reset), .rxd(rxdB), .rx_data(rxData[1]), .rx_valid(rxValid[1]),
        .parity_err(parityErr[1]), .frame_err(frameErr[1]), .match_level(matchLevel[1])
    );

    uart_rx_keymatch #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .MATCH_KEY(9'h078), .HOLD_CYCLES(3000)
    ) dutC (
        .clk(clk), .reset(reset), .rxd(rxdA), .rx_data(rxData[2]), .rx_valid(rxValid[2]),
        .parity_err(parityErr[2]), .frame_err(frameErr[2]), .match_level(matchLevel[2])
    );

    // Pulse counters and match-level run lengths, sampled on the rising edge before outputs update.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rxValid[i] === 1'b1) begin
                validCnt[i]     = validCnt[i] + 1;
                lastValidCyc[i] = cyc;
            end
            if (parityErr[i] === 1'b1) parCnt[i] = parCnt[i] + 1;
            if (frameErr[i] === 1'b1) frameCnt[i] = frameCnt[i] + 1;
            if ((int'(rxValid[i] === 1'b1) + int'(parityErr[i] === 1'b1) + int'(frameErr[i] === 1'b1)) > 1)
                multiPulse = multiPulse + 1;
            if (matchLevel[i] === 1'b1) begin
                if (runCur[i] == 0) rises[i] = rises[i] + 1;
                runCur[i] = runCur[i] + 1;
            end else if (runCur[i] != 0) begin
                lastRun[i] = runCur[i];
                runCur[i]  = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun = testsRun + 1;
        assert (observed === expected) else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            baseValid[i] = validCnt[i];
            basePar[i]   = parCnt[i];
            baseFrame[i] = frameCnt[i];
            baseRises[i] = rises[i];
        end
    endtask

    task automatic driveBit(input int line, input logic v);
        if (line == 1) rxdB = v;
        else rxdA = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus(input int line, input logic [7:0] data, input bit hasPar,
                                 input bit parBit, input bit stopBit);
        driveBit(line, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(line, data[i]);
        if (hasPar) driveBit(line, parBit);
        driveBit(line, stopBit);
    endtask

    task automatic checkCounts(input string tag, input int idx, input int expValid,
                               input int expPar, input int expFrame);
        checkOutput({tag, "_valid"}, 32'(validCnt[idx] - baseValid[idx]), 32'(expValid));
        checkOutput({tag, "_parerr"}, 32'(parCnt[idx] - basePar[idx]), 32'(expPar));
        checkOutput({tag, "_frameerr"}, 32'(frameCnt[idx] - baseFrame[idx]), 32'(expFrame));
    endtask

    initial begin
        longint v1;
        longint v2;
        reset = 1'b1;
        rxdA  = 1'b1;
        rxdB  = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rst%0d_data", i), 32'(rxData[i]), 32'h0);
            checkOutput($sformatf("rst%0d_valid", i), 32'(rxValid[i]), 32'h0);
            checkOutput($sformatf("rst%0d_flags", i), 32'({parityErr[i], frameErr[i], matchLevel[i]}), 32'h0);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] test 1: 0x78, single match window");
        snap();
        applyStimulus(0, 8'h78, 1'b0, 1'b0, 1'b1);
        repeat (1100) @(negedge clk);
        checkCounts("t1", 0, 1, 0, 0);
        checkOutput("t1_data", 32'(rxData[0]), 32'h78);
        checkOutput("t1_rises", 32'(rises[0] - baseRises[0]), 32'd1);
        checkOutput("t1_hold", 32'(lastRun[0]), 32'd1000);

        $display("[TB] test 2: even parity good then bad");
        snap();
        applyStimulus(1, 8'h41, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkCounts("t2a", 1, 1, 0, 0);
        checkOutput("t2a_data", 32'(rxData[1]), 32'h41);
        applyStimulus(1, 8'h41, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        checkCounts("t2b", 1, 1, 1, 0);
        checkOutput("t2b_data", 32'(rxData[1]), 32'h41);
        checkOutput("t2_nomatch", 32'(rises[1] - baseRises[1]), 32'd0);

        $display("[TB] test 3: low stop bit and held break");
        snap();
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        rxdA = 1'b0;
        repeat (5 * BIT_CLKS) @(negedge clk);
        rxdA = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkCounts("t3a", 0, 0, 0, 1);
        checkOutput("t3a_data", 32'(rxData[0]), 32'h78);
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkCounts("t3b", 0, 1, 0, 1);
        checkOutput("t3b_data", 32'(rxData[0]), 32'h55);

        $display("[TB] test 4: 40-clk glitch");
        snap();
        rxdA = 1'b0;
        repeat (40) @(negedge clk);
        rxdA = 1'b1;
        repeat (300) @(negedge clk);
        checkCounts("t4a", 0, 0, 0, 0);
        applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkCounts("t4b", 0, 1, 0, 0);
        checkOutput("t4b_data", 32'(rxData[0]), 32'h33);

        $display("[TB] test 5: retrigger");
        repeat (3200) @(negedge clk);
        snap();
        applyStimulus(0, 8'h78, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_first_valid", 32'(validCnt[2] - baseValid[2]), 32'd1);
        v1 = lastValidCyc[2];
        for (int g = 0; g < 2000 && cyc < v1 + 500; g++) @(negedge clk);
        checkOutput("t5_gap_reached", 32'(cyc >= v1 + 500), 32'd1);
        applyStimulus(0, 8'h78, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_second_valid", 32'(validCnt[2] - baseValid[2]), 32'd2);
        v2 = lastValidCyc[2];
        applyStimulus(0, 8'h61, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_midhold_level", 32'(matchLevel[2]), 32'd1);
        repeat (3500) @(negedge clk);
        checkOutput("t5_rises", 32'(rises[2] - baseRises[2]), 32'd1);
        checkOutput("t5_hold", 32'(lastRun[2]), 32'(v2 - v1 + 3000));
        checkOutput("t5_short_rises", 32'(rises[0] - baseRises[0]), 32'd2);
        checkOutput("t5_short_hold", 32'(lastRun[0]), 32'd1000);

        $display("[TB] test 6: reset mid-frame");
        snap();
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, 1'b0);
        rxdA = 1'b1;
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6_rst_data", 32'(rxData[0]), 32'h0);
        checkOutput("t6_rst_flags", 32'({rxValid[0], parityErr[0], frameErr[0], matchLevel[0]}), 32'h0);
        repeat (79) @(negedge clk);
        for (int i = 0; i < 4; i++) driveBit(0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkCounts("t6a", 0, 0, 0, 0);
        applyStimulus(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkCounts("t6b", 0, 1, 0, 0);
        checkOutput("t6b_data", 32'(rxData[0]), 32'h0F);

        checkOutput("one_hot_pulses", 32'(multiPulse), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
